// File: rtl/eth_tx_frame_arbiter.sv
// GMII transmit arbiter for three frame sources (ARP, ICMP, UDP video).
// ARP has strict priority, and ICMP/UDP share round-robin. A grant lasts
// until the source's done pulse or until the watchdog expires. A fixed
// inter-frame gap follows every grant.
module eth_tx_frame_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [2:0]  src_tx_en,
  input  logic [23:0] src_txd,
  output logic [2:0]  gnt,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        busy,
  output logic        timeout_err
);
  // One extra bit so the terminal count always fits, even for tiny parameters.
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, IFG} state_e;

  state_e            state_q;
  logic [2:0]        gnt_q;
  logic              gmii_tx_en_q;
  logic [7:0]        gmii_txd_q;
  logic              busy_q;
  logic              timeout_err_q;
  logic [WD_W-1:0]   wd_q;
  logic [IFG_W-1:0]  ifg_q;
  // 1 = UDP was the last ICMP/UDP grant, so ICMP wins the next tie.
  logic              last_udp_q;

  logic [2:0]        win_d;
  logic              sel_en, sel_done;
  logic [7:0]        sel_txd;

  // Pick the next owner: ARP first, then the ICMP/UDP source not served last.
  always_comb begin
    win_d = 3'b000;
    if (req[0])                 win_d = 3'b001;
    else if (req[1] && req[2])  win_d = last_udp_q ? 3'b010 : 3'b100;
    else if (req[1])            win_d = 3'b010;
    else if (req[2])            win_d = 3'b100;
  end

  // Route the granted source's lane. Other sources are ignored entirely.
  always_comb begin
    sel_en   = 1'b0;
    sel_txd  = 8'h00;
    sel_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        sel_en   = src_tx_en[i];
        sel_txd  = src_txd[i*8 +: 8];
        sel_done = done[i];
      end
    end
  end

  // Arbitration FSM with all outputs registered. GMII is zeroed unless a
  // frame continues, so leaving BUSY truncates any in-flight bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 3'b000;
      gmii_tx_en_q  <= 1'b0;
      gmii_txd_q    <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
      ifg_q         <= '0;
      last_udp_q    <= 1'b1;
    end else begin
      timeout_err_q <= 1'b0;
      gmii_tx_en_q  <= 1'b0;
      gmii_txd_q    <= 8'h00;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= win_d;
            state_q <= BUSY;
            busy_q  <= 1'b1;
            wd_q    <= '0;
            if (!win_d[0]) last_udp_q <= win_d[2];
          end
        end
        BUSY: begin
          if (sel_done) begin
            gnt_q   <= 3'b000;
            state_q <= IFG;
            ifg_q   <= '0;
          end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            gnt_q         <= 3'b000;
            state_q       <= IFG;
            ifg_q         <= '0;
          end else begin
            wd_q         <= wd_q + WD_W'(1);
            gmii_tx_en_q <= sel_en;
            gmii_txd_q   <= sel_txd;
          end
        end
        IFG: begin
          if (ifg_q == IFG_W'(IFG_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ifg_q   <= '0;
          end else begin
            ifg_q <= ifg_q + IFG_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 3'b000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gmii_tx_en  = gmii_tx_en_q;
  assign gmii_txd    = gmii_txd_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL provide parameter IFG_CYCLES, default 12, minimum idle cycles on GMII between frames.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 2048, maximum cycles a grant may be held without done.
REQ-003 SHALL have port clk  input  1  GMII TX clock (125 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  3  frame requests, level; bit0 ARP, bit1 ICMP, bit2 UDP video.
REQ-006 SHALL have port done  input  3  per-source one-cycle frame-complete pulse, same bit mapping.
REQ-007 SHALL have port src_tx_en  input  3  per-source GMII data-valid.
REQ-008 SHALL have port src_txd  input  24  per-source GMII byte; [7:0] ARP, [15:8] ICMP, [23:16] UDP.
REQ-009 SHALL have port gnt  output  3  one-hot grant level, same bit mapping; source transmits only while its bit is high.
REQ-010 SHALL have port gmii_tx_en  output  1  registered merged GMII data-valid.
REQ-011 SHALL have port gmii_txd  output  8  registered merged GMII byte.
REQ-012 SHALL have port busy  output  1  high in BUSY or IFG states.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on grant watchdog expiry.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, IFG.
REQ-015 IDLE: when req != 0, SHALL select winner, assert its gnt bit on the next clk edge, enter BUSY; req == 0 -> stay IDLE.
REQ-016 Selection SHALL be: ARP strict priority; else ICMP/UDP round-robin -- if both request, the one not granted last wins.
REQ-017 Round-robin pointer SHALL update only on ICMP or UDP grant; ARP grants leave it unchanged; reset value favours ICMP.
REQ-018 req SHALL be sampled only in IDLE; req changes during BUSY/IFG SHALL have no effect.
REQ-019 BUSY: gnt SHALL stay constant; gmii_tx_en/gmii_txd SHALL equal the granted source's src_tx_en/src_txd delayed exactly one cycle.
REQ-020 Non-granted sources' src_tx_en, src_txd and done SHALL be ignored.
REQ-021 done of granted source in BUSY SHALL clear gnt on the next edge and enter IFG.
REQ-022 Watchdog SHALL count cycles in BUSY from 0; at count TIMEOUT_CYCLES-1 without granted done: timeout_err pulses one cycle, gnt clears, enter IFG.
REQ-023 If granted done and watchdog expiry coincide, done SHALL take precedence; no timeout_err.
REQ-024 Outside BUSY, gmii_tx_en SHALL be 0 and gmii_txd 8'h00, starting the cycle after leaving BUSY (truncating any in-flight frame on timeout).
REQ-025 IFG: SHALL hold exactly IFG_CYCLES cycles, then return to IDLE; earliest next gnt is IFG_CYCLES+1 cycles after the cycle gnt cleared.
REQ-026 busy SHALL be 1 in BUSY and IFG, 0 in IDLE.
REQ-027 Watchdog and IFG counters SHALL be sized for their parameters without wrap.

Reset
REQ-028 While rst_n low: state IDLE, gnt 3'b000, gmii_tx_en 0, gmii_txd 8'h00, busy 0, timeout_err 0, counters 0, RR pointer favouring ICMP.
REQ-029 Reset asserted mid-frame SHALL drop gnt and GMII outputs immediately (asynchronous); after release, arbitration restarts from IDLE with no IFG.

Verification
REQ-030 req=3'b111 in IDLE -> gnt=3'b001 next cycle; after ARP done, 12 IFG cycles, then gnt=3'b010 (ICMP).
REQ-031 req=3'b110 held across three frames -> grants ICMP, UDP, ICMP in order, each separated by 12 idle gmii_tx_en cycles.
REQ-032 UDP granted, src_tx_en[2]=1, src_txd[23:16]=8'h55,8'hD5,8'hA1 -> gmii_txd 8'h55,8'hD5,8'hA1 one cycle later; ARP src_tx_en toggling meanwhile never appears on gmii.
REQ-033 Grant ICMP, never pulse done[1] -> timeout_err pulse at BUSY cycle 2047, gnt=0 and gmii_tx_en=0 next cycle, IDLE after 12 cycles.
REQ-034 done[1] and watchdog expiry same cycle -> no timeout_err, normal IFG; done[2] pulsed while ICMP granted -> ignored, grant held.
REQ-035 rst_n low mid UDP frame -> gnt=0, gmii_tx_en=0 immediately; with req=3'b100 after release -> gnt=3'b100 one cycle later.
